// File: rtl/tlb_pkg.sv
// Shared definitions for the fully-associative TLB: entry field layout helpers
// and the flush walk state encoding.
`timescale 1ns/1ps
package tlb_pkg;

  localparam int ASID_W = 8;

  // Entry layout, MSB first: {d, v, g, asid, vpn, pfn}
  function automatic int entry_width(input int vpn_w, input int pfn_w);
    return vpn_w + pfn_w + ASID_W + 3;
  endfunction

  function automatic int asid_lsb(input int vpn_w, input int pfn_w);
    return vpn_w + pfn_w;
  endfunction

  function automatic int g_bit(input int vpn_w, input int pfn_w);
    return vpn_w + pfn_w + ASID_W;
  endfunction

  function automatic int v_bit(input int vpn_w, input int pfn_w);
    return vpn_w + pfn_w + ASID_W + 1;
  endfunction

  function automatic int d_bit(input int vpn_w, input int pfn_w);
    return vpn_w + pfn_w + ASID_W + 2;
  endfunction

  typedef enum logic {
    TLB_IDLE,
    TLB_WALK
  } flush_state_e;

endpackage

// File: rtl/tlb_entry.sv
// One TLB slot: holds a single entry and evaluates the fetch, data and probe
// comparisons against it, returning pfns already masked by the hit.
`timescale 1ns/1ps
module tlb_entry
  import tlb_pkg::*;
#(
  parameter int VPN_WIDTH = 23,
  parameter int PFN_WIDTH = 23
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     we,
  input  logic [entry_width(VPN_WIDTH,PFN_WIDTH)-1:0] wr_entry,
  input  logic                                     clr_v,
  input  logic [ASID_W-1:0]                        c_asid,
  input  logic [VPN_WIDTH-1:0]                     vpn_i,
  input  logic [VPN_WIDTH-1:0]                     vpn_d,
  input  logic [VPN_WIDTH-1:0]                     vpn_p,
  output logic                                     hit_i,
  output logic                                     hit_d,
  output logic                                     hit_p,
  output logic                                     wr_ok,
  output logic [PFN_WIDTH-1:0]                     pfn_i,
  output logic [PFN_WIDTH-1:0]                     pfn_d,
  output logic [entry_width(VPN_WIDTH,PFN_WIDTH)-1:0] entry
);

  localparam int EW       = entry_width(VPN_WIDTH, PFN_WIDTH);
  localparam int ASID_LSB = asid_lsb(VPN_WIDTH, PFN_WIDTH);
  localparam int G_BIT    = g_bit(VPN_WIDTH, PFN_WIDTH);
  localparam int V_BIT    = v_bit(VPN_WIDTH, PFN_WIDTH);
  localparam int D_BIT    = d_bit(VPN_WIDTH, PFN_WIDTH);

  logic [EW-1:0]        entry_q, entry_d;
  logic                 e_v, e_g, e_d, asid_ok;
  logic [ASID_W-1:0]    e_asid;
  logic [VPN_WIDTH-1:0] e_vpn;
  logic [PFN_WIDTH-1:0] e_pfn;

  always_comb begin
    entry_d = entry_q;
    if (we) begin
      entry_d = wr_entry;
    end else if (clr_v) begin
      entry_d[V_BIT] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign e_v     = entry_q[V_BIT];
  assign e_g     = entry_q[G_BIT];
  assign e_d     = entry_q[D_BIT];
  assign e_asid  = entry_q[ASID_LSB +: ASID_W];
  assign e_vpn   = entry_q[PFN_WIDTH +: VPN_WIDTH];
  assign e_pfn   = entry_q[PFN_WIDTH-1:0];
  assign asid_ok = e_g | (e_asid == c_asid);

  assign hit_i = e_v & asid_ok & (e_vpn == vpn_i);
  assign hit_d = e_v & asid_ok & (e_vpn == vpn_d);
  assign hit_p = e_v & asid_ok & (e_vpn == vpn_p);
  assign wr_ok = hit_d & e_d;
  assign pfn_i = {PFN_WIDTH{hit_i}} & e_pfn;
  assign pfn_d = {PFN_WIDTH{hit_d}} & e_pfn;
  assign entry = entry_q;

endmodule

// File: rtl/tlb_nway.sv
// Fully-associative TLB with dual combinational lookup, indexed/random writes,
// a registered probe and a one-slot-per-cycle flush walk (all or by ASID).
`timescale 1ns/1ps
module tlb_nway
  import tlb_pkg::*;
#(
  parameter int LOG_WAYS  = 4,
  parameter int VPN_WIDTH = 23,
  parameter int PFN_WIDTH = 23
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic [LOG_WAYS-1:0]            INDEX,
  input  logic [VPN_WIDTH+PFN_WIDTH+10:0] WR_ENTRY,
  input  logic                           WE_ENTRY,
  input  logic                           WE_RANDOM,
  output logic [VPN_WIDTH+PFN_WIDTH+10:0] RD_ENTRY,
  input  logic [LOG_WAYS-1:0]            WIRED,
  output logic [LOG_WAYS-1:0]            RANDOM,
  input  logic [7:0]                     C_ASID,
  input  logic [VPN_WIDTH-1:0]           VPN_I,
  output logic                           HIT_I,
  output logic [PFN_WIDTH-1:0]           PFN_I,
  input  logic [VPN_WIDTH-1:0]           VPN_D,
  output logic                           HIT_D,
  output logic                           WR_OK,
  output logic [PFN_WIDTH-1:0]           PFN_D,
  output logic                           MULTI_HIT,
  input  logic                           PROBE_REQ,
  input  logic [VPN_WIDTH-1:0]           PROBE_VPN,
  output logic                           PROBE_DONE,
  output logic                           PROBE_MISS,
  output logic [LOG_WAYS-1:0]            PROBE_INDEX,
  input  logic                           FLUSH_REQ,
  input  logic                           FLUSH_BY_ASID,
  input  logic [7:0]                     FLUSH_ASID,
  output logic                           FLUSH_BUSY,
  output logic                           FLUSH_DONE
);

  localparam int NW       = 1 << LOG_WAYS;
  localparam int EW       = entry_width(VPN_WIDTH, PFN_WIDTH);
  localparam int ASID_LSB = asid_lsb(VPN_WIDTH, PFN_WIDTH);
  localparam int G_BIT    = g_bit(VPN_WIDTH, PFN_WIDTH);

  logic [NW-1:0]        hit_i_w, hit_d_w, hit_p_w, wr_ok_w, we_w, clr_w;
  logic [PFN_WIDTH-1:0] pfn_i_w [NW];
  logic [PFN_WIDTH-1:0] pfn_d_w [NW];
  logic [EW-1:0]        entry_w [NW];

  logic [LOG_WAYS-1:0]  random_q, random_d;
  logic                 probe_done_q, probe_done_d;
  logic                 probe_miss_q, probe_miss_d;
  logic [LOG_WAYS-1:0]  probe_index_q, probe_index_d;
  flush_state_e         state_q, state_d;
  logic [LOG_WAYS-1:0]  ptr_q, ptr_d;
  logic                 mode_q, mode_d;
  logic [ASID_W-1:0]    flush_asid_q, flush_asid_d;
  logic                 flush_done_q, flush_done_d;

  logic                 walking, wr_en;
  logic [LOG_WAYS-1:0]  wr_slot, probe_idx;
  logic [PFN_WIDTH-1:0] pfn_i_or, pfn_d_or;
  logic [LOG_WAYS:0]    cnt_i, cnt_d;

  // Writes are dropped while the walk owns the array, so a write and a
  // flush-clear can never target a slot in the same cycle.
  assign walking = (state_q == TLB_WALK);
  assign wr_slot = WE_ENTRY ? INDEX : random_q;
  assign wr_en   = (WE_ENTRY | WE_RANDOM) & ~walking;

  for (genvar gi = 0; gi < NW; gi++) begin : g_slot
    logic              slot_g;
    logic [ASID_W-1:0] slot_asid;

    assign slot_g    = entry_w[gi][G_BIT];
    assign slot_asid = entry_w[gi][ASID_LSB +: ASID_W];
    assign we_w[gi]  = wr_en && (wr_slot == LOG_WAYS'(gi));
    assign clr_w[gi] = walking && (ptr_q == LOG_WAYS'(gi)) &&
                       (!mode_q || (!slot_g && (slot_asid == flush_asid_q)));

    tlb_entry #(
      .VPN_WIDTH (VPN_WIDTH),
      .PFN_WIDTH (PFN_WIDTH)
    ) u_entry (
      .clk      (CLK),
      .rst      (RESET),
      .we       (we_w[gi]),
      .wr_entry (WR_ENTRY),
      .clr_v    (clr_w[gi]),
      .c_asid   (C_ASID),
      .vpn_i    (VPN_I),
      .vpn_d    (VPN_D),
      .vpn_p    (PROBE_VPN),
      .hit_i    (hit_i_w[gi]),
      .hit_d    (hit_d_w[gi]),
      .hit_p    (hit_p_w[gi]),
      .wr_ok    (wr_ok_w[gi]),
      .pfn_i    (pfn_i_w[gi]),
      .pfn_d    (pfn_d_w[gi]),
      .entry    (entry_w[gi])
    );
  end

  always_comb begin
    pfn_i_or = '0;
    pfn_d_or = '0;
    cnt_i    = '0;
    cnt_d    = '0;
    for (int i = 0; i < NW; i++) begin
      pfn_i_or = pfn_i_or | pfn_i_w[i];
      pfn_d_or = pfn_d_or | pfn_d_w[i];
      cnt_i    = cnt_i + {{LOG_WAYS{1'b0}}, hit_i_w[i]};
      cnt_d    = cnt_d + {{LOG_WAYS{1'b0}}, hit_d_w[i]};
    end
  end

  // Scanning downward leaves the lowest matching slot as the final assignment.
  always_comb begin
    probe_idx = '0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (hit_p_w[i]) begin
        probe_idx = LOG_WAYS'(i);
      end
    end
  end

  assign HIT_I     = |hit_i_w;
  assign HIT_D     = |hit_d_w;
  assign WR_OK     = |wr_ok_w;
  assign PFN_I     = pfn_i_or;
  assign PFN_D     = pfn_d_or;
  assign MULTI_HIT = (cnt_i > 1) || (cnt_d > 1);
  assign RD_ENTRY  = entry_w[INDEX];

  always_comb begin
    random_d = (random_q <= WIRED) ? {LOG_WAYS{1'b1}} : random_q - 1'b1;
  end

  always_comb begin
    probe_done_d  = PROBE_REQ;
    probe_miss_d  = probe_miss_q;
    probe_index_d = probe_index_q;
    if (PROBE_REQ) begin
      probe_miss_d  = ~|hit_p_w;
      probe_index_d = probe_idx;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    mode_d       = mode_q;
    flush_asid_d = flush_asid_q;
    flush_done_d = 1'b0;
    case (state_q)
      TLB_IDLE: begin
        if (FLUSH_REQ) begin
          state_d      = TLB_WALK;
          ptr_d        = '0;
          mode_d       = FLUSH_BY_ASID;
          flush_asid_d = FLUSH_ASID;
        end
      end
      TLB_WALK: begin
        ptr_d = ptr_q + 1'b1;
        if (&ptr_q) begin
          state_d      = TLB_IDLE;
          flush_done_d = 1'b1;
        end
      end
      default: state_d = TLB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      random_q      <= {LOG_WAYS{1'b1}};
      probe_done_q  <= 1'b0;
      probe_miss_q  <= 1'b0;
      probe_index_q <= '0;
      state_q       <= TLB_IDLE;
      ptr_q         <= '0;
      mode_q        <= 1'b0;
      flush_asid_q  <= '0;
      flush_done_q  <= 1'b0;
    end else begin
      random_q      <= random_d;
      probe_done_q  <= probe_done_d;
      probe_miss_q  <= probe_miss_d;
      probe_index_q <= probe_index_d;
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      mode_q        <= mode_d;
      flush_asid_q  <= flush_asid_d;
      flush_done_q  <= flush_done_d;
    end
  end

  assign RANDOM      = random_q;
  assign PROBE_DONE  = probe_done_q;
  assign PROBE_MISS  = probe_miss_q;
  assign PROBE_INDEX = probe_index_q;
  assign FLUSH_BUSY  = walking;
  assign FLUSH_DONE  = flush_done_q;

endmodule
